// File: rtl/vram_scanline_arbiter.sv
// vram_scanline_arbiter: shares one single-port synchronous VRAM between the
// CPU bus and a scanline fetch engine that fills the line buffer during hblank.
//
// Ports:
//   clk, resetn                       clock, async active-low reset
//   cpu_valid/addr/wdata/wstrb        CPU request (wstrb==0 is a read), held to ready
//   cpu_ready, cpu_rdata              one-cycle completion pulse and read data
//   fetch_req, fetch_line             hblank start pulse and VRAM line index
//   fetch_busy, fetch_done            fetch in progress / last line-buffer write
//   fetch_overrun                     sticky: a fetch request was dropped
//   ram_en/addr/wdata/wstrb, ram_rdata  VRAM port (read data 1-cycle latency)
//   lb_we, lb_waddr, lb_wdata         line-buffer write port
//
// Build option: define VRAM_ARB_DOUBLE_BUF_EN to select the line-buffer half
// from bit 0 of the fetched line (ping-pong); otherwise the MSB of lb_waddr is 0.

module vram_scanline_arbiter #(
    parameter int RAM_AW         = 14,
    parameter int WORDS_PER_LINE = 40,
    parameter int LINE_SHIFT     = 6,
    parameter int LB_AW          = 7
) (
    input  logic              clk,
    input  logic              resetn,
    input  logic              cpu_valid,
    input  logic [RAM_AW-1:0] cpu_addr,
    input  logic [31:0]       cpu_wdata,
    input  logic [3:0]        cpu_wstrb,
    output logic              cpu_ready,
    output logic [31:0]       cpu_rdata,
    input  logic              fetch_req,
    input  logic [9:0]        fetch_line,
    output logic              fetch_busy,
    output logic              fetch_done,
    output logic              fetch_overrun,
    output logic              ram_en,
    output logic [RAM_AW-1:0] ram_addr,
    output logic [31:0]       ram_wdata,
    output logic [3:0]        ram_wstrb,
    input  logic [31:0]       ram_rdata,
    output logic              lb_we,
    output logic [LB_AW-1:0]  lb_waddr,
    output logic [31:0]       lb_wdata
);

    typedef enum logic [2:0] {
        IDLE,
        CPU_WAIT,
        CPU_DONE,
        FETCH,
        DRAIN
    } state_t;

    localparam logic [LB_AW-1:0] LAST_K = LB_AW'(WORDS_PER_LINE - 1);

    state_t             state_q, state_d;
    logic [LB_AW-1:0]   cnt_q, cnt_d;
    logic [RAM_AW-1:0]  base_q, base_d;
    logic               pend_q, pend_d;
    logic [9:0]         pend_line_q, pend_line_d;
    logic               ovr_q, ovr_d;
    logic [31:0]        rdata_q, rdata_d;
    logic               cpu_rd_q, cpu_rd_d;
    logic               lb_we_q, lb_we_d;
    logic [LB_AW-2:0]   lb_k_q, lb_k_d;
    logic [9:0]         start_line;
    logic               start_fetch;

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state_q     <= IDLE;
            cnt_q       <= '0;
            base_q      <= '0;
            pend_q      <= 1'b0;
            pend_line_q <= '0;
            ovr_q       <= 1'b0;
            rdata_q     <= '0;
            cpu_rd_q    <= 1'b0;
            lb_we_q     <= 1'b0;
            lb_k_q      <= '0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            base_q      <= base_d;
            pend_q      <= pend_d;
            pend_line_q <= pend_line_d;
            ovr_q       <= ovr_d;
            rdata_q     <= rdata_d;
            cpu_rd_q    <= cpu_rd_d;
            lb_we_q     <= lb_we_d;
            lb_k_q      <= lb_k_d;
        end
    end

    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        base_d      = base_q;
        pend_d      = pend_q;
        pend_line_d = pend_line_q;
        ovr_d       = ovr_q;
        rdata_d     = rdata_q;
        cpu_rd_d    = cpu_rd_q;
        lb_we_d     = 1'b0;
        lb_k_d      = lb_k_q;
        start_fetch = 1'b0;
        // A deferred request must use the line index captured with it.
        start_line  = pend_q ? pend_line_q : fetch_line;
        ram_en      = 1'b0;
        ram_addr    = '0;
        ram_wdata   = '0;
        ram_wstrb   = '0;
        cpu_ready   = 1'b0;
        fetch_busy  = 1'b0;
        fetch_done  = 1'b0;

        unique case (state_q)
            IDLE: begin
                if (fetch_req || pend_q) begin
                    start_fetch = 1'b1;
                end else if (cpu_valid && resetn) begin
                    // resetn gate keeps the RAM port quiet during reset.
                    ram_en    = 1'b1;
                    ram_addr  = cpu_addr;
                    ram_wdata = cpu_wdata;
                    ram_wstrb = cpu_wstrb;
                    cpu_rd_d  = (cpu_wstrb == 4'd0);
                    state_d   = CPU_WAIT;
                end
            end
            CPU_WAIT: begin
                if (cpu_rd_q) begin
                    rdata_d = ram_rdata;
                end
                if (fetch_req) begin
                    if (pend_q) begin
                        ovr_d = 1'b1;
                    end else begin
                        pend_d      = 1'b1;
                        pend_line_d = fetch_line;
                    end
                end
                state_d = CPU_DONE;
            end
            CPU_DONE: begin
                cpu_ready = 1'b1;
                if (fetch_req && pend_q) begin
                    ovr_d = 1'b1;
                end
                // Deferred fetch starts right after the CPU completes.
                if (fetch_req || pend_q) begin
                    start_fetch = 1'b1;
                end else begin
                    state_d = IDLE;
                end
            end
            FETCH: begin
                fetch_busy = 1'b1;
                ram_en     = 1'b1;
                ram_addr   = base_q + RAM_AW'(cnt_q);
                lb_we_d    = 1'b1;
                lb_k_d     = cnt_q[LB_AW-2:0];
                if (fetch_req) begin
                    ovr_d = 1'b1;
                end
                if (cnt_q == LAST_K) begin
                    state_d = DRAIN;
                end else begin
                    cnt_d = cnt_q + LB_AW'(1);
                end
            end
            DRAIN: begin
                fetch_busy = 1'b1;
                fetch_done = 1'b1;
                if (fetch_req) begin
                    ovr_d = 1'b1;
                end
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        if (start_fetch) begin
            state_d = FETCH;
            cnt_d   = '0;
            pend_d  = 1'b0;
            // Line bits that do not fit the RAM address fall off the top.
            base_d  = RAM_AW'(start_line) << LINE_SHIFT;
        end
    end

    assign cpu_rdata     = rdata_q;
    assign fetch_overrun = ovr_q;
    assign lb_we         = lb_we_q;
    assign lb_wdata      = lb_we_q ? ram_rdata : 32'd0;

`ifdef VRAM_ARB_DOUBLE_BUF_EN
    logic buf_q;

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            buf_q <= 1'b0;
        end else if (start_fetch) begin
            buf_q <= start_line[0];
        end
    end

    assign lb_waddr = {buf_q, lb_k_q};
`else
    assign lb_waddr = {1'b0, lb_k_q};
`endif

endmodule

// File: tb/tb_vram_scanline_arbiter.sv
// tb_vram_scanline_arbiter: table-driven CPU vectors plus scoreboarded
// scanline fetches against a behavioural single-port VRAM.

module tb_vram_scanline_arbiter;

    logic        clk = 1'b0;
    logic        resetn;
    logic        cpu_valid;
    logic [13:0] cpu_addr;
    logic [31:0] cpu_wdata;
    logic [3:0]  cpu_wstrb;
    logic        cpu_ready;
    logic [31:0] cpu_rdata;
    logic        fetch_req;
    logic [9:0]  fetch_line;
    logic        fetch_busy;
    logic        fetch_done;
    logic        fetch_overrun;
    logic        ram_en;
    logic [13:0] ram_addr;
    logic [31:0] ram_wdata;
    logic [3:0]  ram_wstrb;
    logic [31:0] ram_rdata;
    logic        lb_we;
    logic [6:0]  lb_waddr;
    logic [31:0] lb_wdata;

    vram_scanline_arbiter dut (
        .clk(clk), .resetn(resetn),
        .cpu_valid(cpu_valid), .cpu_addr(cpu_addr),
        .cpu_wdata(cpu_wdata), .cpu_wstrb(cpu_wstrb),
        .cpu_ready(cpu_ready), .cpu_rdata(cpu_rdata),
        .fetch_req(fetch_req), .fetch_line(fetch_line),
        .fetch_busy(fetch_busy), .fetch_done(fetch_done),
        .fetch_overrun(fetch_overrun),
        .ram_en(ram_en), .ram_addr(ram_addr),
        .ram_wdata(ram_wdata), .ram_wstrb(ram_wstrb),
        .ram_rdata(ram_rdata),
        .lb_we(lb_we), .lb_waddr(lb_waddr), .lb_wdata(lb_wdata)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;
    int cyc = 0;
    int acc_cyc = -100;
    int drain_cyc = -100;
    int start_cyc = -100;
    int last_rdy = -100;
    int done_cnt = 0;
    int busy_run = 0;

    always @(posedge clk) cyc <= cyc + 1;

    // VRAM model: untouched words hold a fixed preload pattern.
    logic [31:0] mem [16384];
    bit          written [16384];

    function automatic logic [31:0] pat(input logic [13:0] a);
        case (a)
            14'h0010: return 32'hDEADBEEF;
            14'h0020: return 32'h00000000;
            14'h3FFF: return 32'hFEEDF00D;
            default:  return {2'b0, a, 2'b0, a} ^ 32'h5A5A0000;
        endcase
    endfunction

    function automatic logic [31:0] model_rd(input logic [13:0] a);
        return written[a] ? mem[a] : pat(a);
    endfunction

    always @(posedge clk) begin
        if (ram_en) begin
            logic [31:0] w;
            w = model_rd(ram_addr);
            ram_rdata <= w;
            if (ram_wstrb != 4'd0) begin
                for (int b = 0; b < 4; b++)
                    if (ram_wstrb[b]) w[b*8 +: 8] = ram_wdata[b*8 +: 8];
                mem[ram_addr] <= w;
                written[ram_addr] <= 1'b1;
            end
        end
    end

    task automatic check(input string name, input logic [127:0] act,
                         input logic [127:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    function automatic logic [127:0] all_outs();
        return {cpu_ready, cpu_rdata, fetch_busy, fetch_done, fetch_overrun,
                ram_en, ram_addr, ram_wdata, ram_wstrb,
                lb_we, lb_waddr, lb_wdata};
    endfunction

    typedef struct {
        logic [6:0]  waddr;
        logic [31:0] data;
        bit          last;
    } lb_exp_t;

    lb_exp_t     lbq [$];
    logic [13:0] addrq [$];

    task automatic push_fetch(input logic [9:0] line);
        logic [13:0] base;
        logic [13:0] a;
        logic        msb;
        base = 14'(line * 64);
`ifdef VRAM_ARB_DOUBLE_BUF_EN
        msb = line[0];
`else
        msb = 1'b0;
`endif
        for (int k = 0; k < 40; k++) begin
            lb_exp_t e;
            a = base + 14'(k);
            addrq.push_back(a);
            e.waddr = {msb, 6'(k)};
            e.data  = model_rd(a);
            e.last  = (k == 39);
            lbq.push_back(e);
        end
    endtask

    always @(negedge clk) begin
        if (!resetn) begin
            busy_run = 0;
        end else begin
            if (ram_en && !fetch_busy) acc_cyc = cyc;
            if (ram_en && fetch_busy) begin
                check("fetch_addr_expected", addrq.size() != 0, 1);
                if (addrq.size() != 0)
                    check("fetch_addr", ram_addr, addrq.pop_front());
                check("fetch_wstrb", ram_wstrb, 0);
            end
            if (lb_we) begin
                check("lb_write_expected", lbq.size() != 0, 1);
                if (lbq.size() != 0) begin
                    lb_exp_t e;
                    e = lbq.pop_front();
                    check("lb_waddr", lb_waddr, e.waddr);
                    check("lb_wdata", lb_wdata, e.data);
                    check("fetch_done_on_last", fetch_done, e.last);
                end
            end else if (fetch_done) begin
                check("fetch_done_with_we", lb_we, 1);
            end
            if (fetch_done) begin
                done_cnt++;
                drain_cyc = cyc;
            end
            if (fetch_busy) begin
                if (busy_run == 0) start_cyc = cyc;
                busy_run++;
            end else if (busy_run != 0) begin
                check("busy_len", busy_run, 41);
                busy_run = 0;
            end
        end
    end

    typedef struct {
        logic [13:0] addr;
        logic [31:0] wdata;
        logic [3:0]  wstrb;
        logic [31:0] exp_rdata;
    } cpu_vec_t;

    task automatic cpu_op(input cpu_vec_t v);
        int n;
        cpu_valid = 1'b1;
        cpu_addr  = v.addr;
        cpu_wdata = v.wdata;
        cpu_wstrb = v.wstrb;
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!cpu_ready && n < 200);
        check("cpu_ready_seen", cpu_ready, 1);
        last_rdy = cyc;
        #1;
        check("cpu_latency", last_rdy - acc_cyc, 2);
        if (v.wstrb == 4'd0) check("cpu_rdata", cpu_rdata, v.exp_rdata);
        @(posedge clk);
        #1;
        cpu_valid = 1'b0;
        cpu_wstrb = 4'd0;
    endtask

    task automatic pulse_fetch(input logic [9:0] line, input bit expect_run);
        fetch_req  = 1'b1;
        fetch_line = line;
        if (expect_run) push_fetch(line);
        @(posedge clk);
        #1;
        fetch_req  = 1'b0;
        fetch_line = 10'h000;
    endtask

    task automatic wait_done();
        int d0;
        int n;
        d0 = done_cnt;
        n = 0;
        while (done_cnt == d0 && n < 100) begin
            @(negedge clk);
            #1;
            n++;
        end
        check("fetch_completed", done_cnt != d0, 1);
    endtask

    task automatic align();
        @(posedge clk);
        #1;
    endtask

    cpu_vec_t vecs [6];

    initial begin
        vecs[0] = '{14'h0010, 32'h0,        4'h0, 32'hDEADBEEF};
        vecs[1] = '{14'h0010, 32'h12345678, 4'hF, 32'h0};
        vecs[2] = '{14'h0010, 32'h0,        4'h0, 32'h12345678};
        vecs[3] = '{14'h0020, 32'hAABBCCDD, 4'h5, 32'h0};
        vecs[4] = '{14'h0020, 32'h0,        4'h0, 32'h00BB00DD};
        vecs[5] = '{14'h3FFF, 32'h0,        4'h0, 32'hFEEDF00D};

        resetn     = 1'b0;
        cpu_valid  = 1'b1;
        cpu_addr   = 14'h0005;
        cpu_wdata  = 32'h0;
        cpu_wstrb  = 4'hF;
        fetch_req  = 1'b0;
        fetch_line = 10'h0;
        repeat (3) @(negedge clk);
        check("reset_outputs", all_outs(), 0);
        cpu_valid = 1'b0;
        cpu_wstrb = 4'h0;
        align();
        resetn = 1'b1;
        @(negedge clk);
        check("overrun_after_reset", fetch_overrun, 0);

        for (int i = 0; i < 6; i++) begin
            align();
            cpu_op(vecs[i]);
        end

        // Plain fetch of line 3: addresses 192..231.
        align();
        pulse_fetch(10'd3, 1);
        wait_done();
        check("no_overrun_plain", fetch_overrun, 0);

        // CPU and fetch together: fetch first, CPU accepted after DRAIN.
        align();
        fork
            pulse_fetch(10'd7, 1);
            cpu_op(vecs[2]);
        join
        check("cpu_after_drain", acc_cyc - drain_cyc, 1);

        // Fetch request while the CPU read is in CPU_WAIT.
        align();
        fork
            cpu_op(vecs[4]);
            begin
                align();
                pulse_fetch(10'd6, 1);
            end
        join
        wait_done();
        check("fetch_after_cpu_done", start_cyc - last_rdy, 1);
        check("no_overrun_pending", fetch_overrun, 0);

        // Second request mid-fetch is dropped and flagged.
        align();
        pulse_fetch(10'd5, 1);
        repeat (9) align();
        pulse_fetch(10'd9, 0);
        @(negedge clk);
        check("overrun_set", fetch_overrun, 1);
        wait_done();
        check("overrun_sticky", fetch_overrun, 1);

        // Upper line bits dropped: 0x2FF -> base 0x3FC0.
        align();
        pulse_fetch(10'h2FF, 1);
        wait_done();
        check("overrun_still", fetch_overrun, 1);

        // Reset in the middle of a fetch.
        align();
        pulse_fetch(10'd2, 1);
        repeat (5) @(posedge clk);
        #3;
        resetn    = 1'b0;
        cpu_valid = 1'b1;
        cpu_addr  = 14'h0011;
        #1;
        check("async_reset_outputs", all_outs(), 0);
        lbq.delete();
        addrq.delete();
        repeat (3) @(negedge clk);
        check("reset_hold_outputs", all_outs(), 0);
        cpu_valid = 1'b0;
        align();
        resetn = 1'b1;
        @(negedge clk);
        check("overrun_cleared", fetch_overrun, 0);
        check("busy_after_reset", fetch_busy, 0);
        align();
        cpu_op(vecs[5]);

        repeat (3) @(negedge clk);
        check("lb_queue_drained", lbq.size(), 0);
        check("addr_queue_drained", addrq.size(), 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1);
    end

endmodule
